// File: rtl/fir_tree_pipe.sv
// fir_tree_pipe: pipelined FIR filter, registered pairwise adder tree.
// Ports: clk, rst (async low), clr, in_valid/in_data, coef_wr/addr/data, out_valid/out_data.
module fir_tree_pipe #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  localparam int LVL   = $clog2(TAPS),
  localparam int OUT_W = DATA_W + COEF_W + LVL,
  localparam int LAT   = LVL + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                    coef_wr,
  input  logic [LVL-1:0]          coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data
);

  // Tree is a heap: node k sums children 2k+1 and 2k+2.
  // Leaves TAPS-1 .. 2*TAPS-2 hold the products, node 0 is the result.
  localparam int NODES = 2 * TAPS - 1;

  logic signed [COEF_W-1:0] h    [TAPS];
  logic signed [DATA_W-1:0] dl   [TAPS];
  logic signed [OUT_W-1:0]  node [NODES];

  // pv[0]: delay line, pv[1]: products, pv[2+m]: tree level m.
  logic pv [LAT];

  function automatic logic signed [OUT_W-1:0] mul(
    input logic signed [DATA_W-1:0] a,
    input logic signed [COEF_W-1:0] b
  );
    logic signed [OUT_W-1:0] ax;
    logic signed [OUT_W-1:0] bx;
    ax = {{(OUT_W-DATA_W){a[DATA_W-1]}}, a};
    bx = {{(OUT_W-COEF_W){b[COEF_W-1]}}, b};
    return ax * bx;
  endfunction

  function automatic int dep(input int k);
    int d;
    d = 0;
    for (int n = k + 1; n > 1; n = n >> 1)
      d++;
    return d;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++)
        h[i] <= '0;
    end else if (coef_wr) begin
      h[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++)
        dl[i] <= '0;
      for (int i = 0; i < LAT; i++)
        pv[i] <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < TAPS; i++)
        dl[i] <= '0;
      for (int i = 0; i < LAT; i++)
        pv[i] <= 1'b0;
    end else begin
      pv[0] <= in_valid;
      for (int i = 1; i < LAT; i++)
        pv[i] <= pv[i-1];
      if (in_valid) begin
        dl[0] <= in_data;
        for (int i = 1; i < TAPS; i++)
          dl[i] <= dl[i-1];
      end
    end
  end

  // Stages load only behind a valid, so the root holds between results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NODES; k++)
        node[k] <= '0;
    end else if (!clr) begin
      if (pv[0]) begin
        for (int i = 0; i < TAPS; i++)
          node[TAPS-1+i] <= mul(dl[i], h[i]);
      end
      for (int k = 0; k < TAPS - 1; k++) begin
        if (pv[LAT-2-dep(k)])
          node[k] <= node[2*k+1] + node[2*k+2];
      end
    end
  end

  assign out_valid = pv[LAT-1];
  assign out_data  = node[0];

endmodule

// File: tb/tb_fir_tree_pipe.sv
// tb_fir_tree_pipe: directed vectors, scoreboard queue, negedge monitor.
// Drives fir_tree_pipe with defaults (8 taps, 16x16 -> 35 bits).
module tb_fir_tree_pipe;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int OW   = 35;
  localparam int LAT  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic coef_wr = 1'b0;
  logic [2:0] coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic out_valid;
  logic signed [OW-1:0] out_data;

  fir_tree_pipe dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .in_valid(in_valid),
    .in_data(in_data),
    .coef_wr(coef_wr),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic signed [OW-1:0] v;
    int due;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic signed [OW-1:0] last = '0;

  task automatic chk(input string nm,
                     input logic signed [OW-1:0] got,
                     input logic signed [OW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic chk_i(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious: out_valid=1 (data %0d) at cycle %0d, want none",
                 out_data, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("out_data", out_data, mon_e.v);
        chk_i("latency cycle", cyc, mon_e.due);
      end
      last = out_data;
    end else begin
      if (q.size() > 0 && q[0].due <= cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL missing: out_valid=0 at cycle %0d, want %0d due %0d",
                 cyc, q[0].v, q[0].due);
        void'(q.pop_front());
      end
      if (!rst) last = '0;
      chk("hold out_data", out_data, last);
    end
  end

  task automatic tick(input logic iv,
                      input logic signed [DW-1:0] d,
                      input logic signed [OW-1:0] e);
    exp_t t;
    in_valid = iv;
    in_data = d;
    if (iv && rst && !clr) begin
      t.v = e;
      t.due = cyc + LAT;
      q.push_back(t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = '0;
    clr = 1'b0;
    coef_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, '0);
  endtask

  task automatic wr(input int a, input int v);
    coef_wr = 1'b1;
    coef_addr = 3'(a);
    coef_data = 16'(v);
    tick(1'b0, '0, '0);
  endtask

  task automatic do_clr(input logic iv, input logic signed [DW-1:0] d);
    clr = 1'b1;
    while (q.size() > 0 && q[$].due > cyc)
      void'(q.pop_back());
    tick(iv, d, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset out_data", out_data, '0);
    chk_i("reset out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // impulse, h = 1..8
    for (int i = 0; i < 8; i++) wr(i, i + 1);
    tick(1'b1, 16'sd1, 35'sd1);
    for (int i = 1; i < 8; i++) tick(1'b1, 16'sd0, OW'(i + 1));
    tick(1'b1, 16'sd0, 35'sd0);
    idle(6);

    // impulse with two-cycle gaps
    tick(1'b1, 16'sd1, 35'sd1);
    idle(2);
    for (int i = 1; i < 8; i++) begin
      tick(1'b1, 16'sd0, OW'(i + 1));
      idle(2);
    end
    tick(1'b1, 16'sd0, 35'sd0);
    idle(6);

    // live write of h[0]: 1 -> 5 with the sample of 2
    tick(1'b1, 16'sd3, 35'sd3);
    coef_wr = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'sd5;
    tick(1'b1, 16'sd2, 35'sd16);
    tick(1'b1, 16'sd0, 35'sd13);
    idle(6);

    // clr mid-stream, simultaneous sample discarded
    do_clr(1'b0, '0);
    tick(1'b1, 16'sd1, 35'sd5);
    tick(1'b1, 16'sd1, 35'sd7);
    tick(1'b1, 16'sd1, 35'sd10);
    do_clr(1'b1, 16'sd9);
    chk_i("clr out_valid", int'(out_valid), 0);
    tick(1'b1, 16'sd1, 35'sd5);
    tick(1'b1, 16'sd0, 35'sd2);
    tick(1'b1, 16'sd0, 35'sd3);
    tick(1'b1, 16'sd0, 35'sd4);
    idle(6);

    // extremes: all -32768
    for (int i = 0; i < 8; i++) wr(i, -32768);
    do_clr(1'b0, '0);
    for (int k = 1; k < 8; k++)
      tick(1'b1, -16'sd32768, OW'(k) * 35'sd1073741824);
    tick(1'b1, -16'sd32768, 35'sd8589934592);
    idle(6);

    // async reset mid-stream
    tick(1'b1, 16'sd1, 35'sd7516160000);
    tick(1'b1, 16'sd1, 35'sd6442385408);
    tick(1'b1, 16'sd1, 35'sd5368610816);
    idle(3);
    chk_i("pre-reset out_valid", int'(out_valid), 1);
    chk("pre-reset out_data", out_data, 35'sd6442385408);
    #2;
    rst = 1'b0;
    q.delete();
    #1;
    chk_i("async rst out_valid", int'(out_valid), 0);
    chk("async rst out_data", out_data, '0);
    coef_wr = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'sd7;
    tick(1'b1, 16'sd3, '0);
    rst = 1'b1;
    idle(8);
    tick(1'b1, 16'sd1, 35'sd0);
    tick(1'b1, 16'sd0, 35'sd0);
    tick(1'b1, 16'sd0, 35'sd0);
    idle(8);

    chk_i("queue drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
